// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encoding and the
// index-to-one-hot decode function used by the combinational decoder.
package onehot_pkg;

  // Largest supported index width; the decode helper works on this width and
  // callers truncate to their own output width.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

  // Encoding of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Returns a one-hot vector with the bit for index set. With msb_first the
  // index counts down from bit (2**sel_w - 1), so index 0 is the top bit.
  // index must be below 2**sel_w.
  function automatic logic [MAX_OUT_W-1:0] decode(input int unsigned index,
                                                 input int unsigned sel_w,
                                                 input bit          msb_first);
    logic [MAX_OUT_W-1:0] v;
    logic [MAX_SEL_W-1:0] pos;
    int unsigned          out_w;
    v     = '0;
    out_w = 32'd1 << sel_w;
    pos   = MAX_SEL_W'(msb_first ? (out_w - 32'd1 - index) : index);
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control and select bus of the one-hot scan decoder. The master drives the
// controls and observes the select outputs; the decoder is the slave.
interface onehot_scan_decoder_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic               en;
  logic               clr;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (
    output en, clr, mode, load, sel, dwell,
    input  y, idx, valid, wrap
  );

  modport slave (
    input  en, clr, mode, load, sel, dwell,
    output y, idx, valid, wrap
  );

endinterface

// File: rtl/onehot_decode.sv
// Combinational index to one-hot decoder, parametrised successor of the fixed
// 3-to-8 decoder. Exactly one output bit is set for every index.
module onehot_decode
  import onehot_pkg::*;
#(
  parameter int unsigned SEL_W     = 3,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned OUT_W    = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y
);

  // Decode at the package's maximum width and keep only the low OUT_W bits.
  assign y = OUT_W'(decode(32'(sel), SEL_W, MSB_FIRST));

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a scan sequencer. In direct mode the loaded
// index is held; in scan mode the active output steps through every position,
// holding each for dwell+1 enabled cycles and pulsing wrap on the 7->0 style
// rollover. All state lives in this module; decode is a separate block.
module onehot_scan_decoder
  import onehot_pkg::*;
#(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned DWELL_W   = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_scan_decoder_if.slave  bus
);

  localparam int unsigned OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q,  wrap_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic               mode_q,  mode_d;
  logic [OUT_W-1:0]   dec_y;

  // Next-state: en gates everything, then clr > load > mode change > scan step.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    if (bus.en) begin
      mode_d = bus.mode;
      if (bus.clr) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end else if (bus.load) begin
        idx_d   = bus.sel;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else if (bus.mode != mode_q) begin
        // Restart the dwell on a mode switch; position and valid are kept.
        cnt_d = '0;
      end else if (bus.mode == MODE_SCAN && valid_q) begin
        // >= so a dwell lowered below the running count steps immediately.
        if (cnt_q >= bus.dwell) begin
          cnt_d  = '0;
          idx_d  = idx_q + 1'b1;
          wrap_d = (idx_q == LAST_IDX);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_DIRECT;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Decoder on the idx register output; y is driven only from flops.
  onehot_decode #(
    .SEL_W    (SEL_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_decode (
    .sel(idx_q),
    .y  (dec_y)
  );

  // Outputs: y is blanked whenever no index is valid.
  always_comb begin
    bus.y     = valid_q ? dec_y : '0;
    bus.idx   = idx_q;
    bus.valid = valid_q;
    bus.wrap  = wrap_q;
  end

endmodule
